// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_pkg
//  Description : Shared types for the multi-channel ADC capture sequencer.
//                - capture_state_t : sequencer FSM encoding (exported on the
//                                    'state' debug port, so values are fixed)
//                - capture_mode_t  : one-shot / continuous record mode
//                - ch_idx_width()  : width of a channel index, never below 1
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_EMPTY = 3'd1,
        CAPTURE    = 3'd2,
        FINISH     = 3'd3
    } capture_state_t;

    typedef enum logic {
        ONE_SHOT   = 1'b0,
        CONTINUOUS = 1'b1
    } capture_mode_t;

    // A single-channel build still needs a 1-bit channel tag.
    function automatic int ch_idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage : adc_capture_pkg
`default_nettype wire

// File: rtl/channel_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : channel_serializer
//  Description : Snapshots all channels on i_load and emits the enabled ones,
//                lowest index first, one per cycle, as a registered write.
//  Ports       : clk, rstn        - clock, async active-low reset
//                i_flush          - drop everything pending, no write next cycle
//                i_load           - take a new frame (i_data, i_mask) this cycle
//                i_full           - sink full: the write chosen this cycle is
//                                   dropped but its channel is still retired
//                o_valid/o_data/o_ch - registered write strobe, sample, tag
//                o_last           - the channel retired this cycle ends the frame
//                o_busy           - channels still pending from an earlier load
//  Revision    : 1.0 - initial release
// ============================================================================
module channel_serializer
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               i_flush,
    input  logic                               i_load,
    input  logic                               i_full,
    input  logic [NUM_CH-1:0]                  i_mask,
    input  logic [NUM_CH*SAMPLE_W-1:0]         i_data,
    output logic                               o_valid,
    output logic [SAMPLE_W-1:0]                o_data,
    output logic [ch_idx_width(NUM_CH)-1:0]    o_ch,
    output logic                               o_last,
    output logic                               o_busy
);

    localparam int c_CH_W = ch_idx_width(NUM_CH);

    logic [NUM_CH*SAMPLE_W-1:0] r_snap;
    logic [NUM_CH-1:0]          r_pend;

    logic [NUM_CH-1:0]          w_src_mask;
    logic [NUM_CH-1:0]          w_rest;
    logic [NUM_CH*SAMPLE_W-1:0] w_src_data;
    logic [SAMPLE_W-1:0]        w_sel_data;
    logic [c_CH_W-1:0]          w_sel_ch;
    logic                       w_any;

    // On a load the first channel is taken straight from the live input so
    // that it reaches the output register one cycle after the tick.
    always_comb begin
        w_src_mask = i_load ? i_mask : r_pend;
        w_src_data = i_load ? i_data : r_snap;
        w_any      = |w_src_mask;
        w_rest     = w_src_mask & (w_src_mask - NUM_CH'(1));   // clear lowest set bit
        w_sel_ch   = '0;
        w_sel_data = '0;
        // Descending scan: the last hit is the lowest set index.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_src_mask[i]) begin
                w_sel_ch   = c_CH_W'(i);
                w_sel_data = w_src_data[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    assign o_last = w_any && (w_rest == '0);
    assign o_busy = |r_pend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_snap  <= '0;
            r_pend  <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
        end else if (i_flush) begin
            r_pend  <= '0;
            o_valid <= 1'b0;
        end else begin
            r_pend  <= w_rest;
            if (i_load) begin
                r_snap <= i_data;
            end
            o_valid <= w_any && !i_full;
            if (w_any) begin
                o_data <= w_sel_data;
                o_ch   <= w_sel_ch;
            end
        end
    end

endmodule : channel_serializer
`default_nettype wire

// File: rtl/adc_capture_seq.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_seq
//  Description : Multi-channel ADC capture sequencer. Takes a decimated
//                parallel snapshot of NUM_CH channels and serialises the
//                enabled ones into a channel-tagged FIFO write stream.
//  Ports       : clk, rstn                  - clock, async active-low reset
//                start/stop/mode            - record control (start is edge)
//                ch_mask/rec_len/decim      - record setup, latched on start
//                aligned, adc_data          - deserialiser status and samples
//                fifo_rst/full/empty        - FIFO write-side status
//                wr_en/wr_data/wr_ch        - FIFO write stream
//                busy/done/overflow/state   - status and debug
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_seq
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SAMPLE_W  = 16,
    parameter int REC_LEN_W = 16,
    parameter int DECIM_W   = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            mode,
    input  logic [NUM_CH-1:0]               ch_mask,
    input  logic [REC_LEN_W-1:0]            rec_len,
    input  logic [DECIM_W-1:0]              decim,
    input  logic                            aligned,
    input  logic [NUM_CH*SAMPLE_W-1:0]      adc_data,
    input  logic                            fifo_rst,
    input  logic                            fifo_full,
    input  logic                            fifo_empty,
    output logic                            wr_en,
    output logic [SAMPLE_W-1:0]             wr_data,
    output logic [ch_idx_width(NUM_CH)-1:0] wr_ch,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow,
    output logic [2:0]                      state
);

    capture_state_t         r_state, w_next;
    capture_mode_t          r_mode;
    logic                   r_start_d;
    logic [NUM_CH-1:0]      r_mask;
    logic [REC_LEN_W-1:0]   r_rec_len, r_frame_cnt, w_frame_nxt;
    logic [DECIM_W-1:0]     r_decim, r_decim_cnt;
    logic                   r_rec_done, r_overflow, r_busy, r_done;

    logic w_accept, w_in_cap, w_stop_now, w_tick, w_load, w_overrun, w_drop;
    logic w_frame_end, w_rec_reached, w_ser_busy, w_ser_last;

    assign w_accept = (r_state == IDLE) && start && !r_start_d && aligned
                      && !fifo_rst && (ch_mask != '0) && (rec_len != '0);

    assign w_in_cap = (r_state == CAPTURE) && !fifo_rst;

    // Frame boundary with stop requested: nothing pending, and the tick that
    // would open a new frame this cycle is withheld.
    assign w_stop_now = w_in_cap && (r_mode == CONTINUOUS) && stop && !w_ser_busy;

    // r_rec_done keeps a tick from opening a frame beyond the record end.
    assign w_tick    = w_in_cap && (r_decim_cnt == '0) && !r_rec_done && !w_stop_now;
    assign w_load    = w_tick && !w_ser_busy;
    assign w_overrun = w_tick &&  w_ser_busy;
    assign w_drop    = w_in_cap && (w_load || w_ser_busy) && fifo_full;

    assign w_frame_end   = w_in_cap && w_ser_last;
    assign w_frame_nxt   = r_frame_cnt + REC_LEN_W'(1);
    assign w_rec_reached = (w_frame_nxt == r_rec_len);

    channel_serializer #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W)
    ) u_ser (
        .clk     (clk),
        .rstn    (rstn),
        .i_flush (!w_in_cap),
        .i_load  (w_load),
        .i_full  (fifo_full),
        .i_mask  (r_mask),
        .i_data  (adc_data),
        .o_valid (wr_en),
        .o_data  (wr_data),
        .o_ch    (wr_ch),
        .o_last  (w_ser_last),
        .o_busy  (w_ser_busy)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (w_accept) w_next = WAIT_EMPTY;
            WAIT_EMPTY: if (fifo_rst) w_next = IDLE;
                        else if (fifo_empty) w_next = CAPTURE;
            CAPTURE:    if (fifo_rst) w_next = IDLE;
                        else if (r_rec_done || w_stop_now) w_next = FINISH;
            FINISH:     w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with 'state'.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == FINISH);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_start_d   <= 1'b0;
            r_mode      <= ONE_SHOT;
            r_mask      <= '0;
            r_rec_len   <= '0;
            r_decim     <= '0;
            r_decim_cnt <= '0;
            r_frame_cnt <= '0;
            r_rec_done  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_start_d <= start;
            if (w_accept) begin
                r_mode      <= capture_mode_t'(mode);
                r_mask      <= ch_mask;
                r_rec_len   <= rec_len;
                r_decim     <= decim;
                r_decim_cnt <= '0;          // first tick on the first CAPTURE cycle
                r_frame_cnt <= '0;
                r_rec_done  <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_in_cap) begin
                    r_decim_cnt <= (r_decim_cnt == '0) ? r_decim
                                                       : r_decim_cnt - DECIM_W'(1);
                end
                if (w_frame_end) begin
                    r_frame_cnt <= w_rec_reached ? '0 : w_frame_nxt;
                end
                r_rec_done <= w_frame_end && w_rec_reached && (r_mode == ONE_SHOT);
                if (w_overrun || w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign state    = r_state;

endmodule : adc_capture_seq
`default_nettype wire

// File: tb/tb_adc_capture_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_capture_seq
//  Description : Directed self-checking bench for adc_capture_seq (NUM_CH=4).
//                Writes and done pulses are logged at the falling edge with
//                the index of the rising edge that produced them; each test
//                compares the log against hand-derived cycle offsets from the
//                edge that accepted its start (e1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture_seq;

    logic        clk = 1'b0;
    logic        rstn, start, stop, mode, aligned, fifo_rst, fifo_full, fifo_empty;
    logic [3:0]  ch_mask;
    logic [15:0] rec_len;
    logic [7:0]  decim;
    logic [63:0] adc_data;
    logic        wr_en, busy, done, overflow;
    logic [15:0] wr_data;
    logic [1:0]  wr_ch;
    logic [2:0]  state;

    adc_capture_seq #(
        .NUM_CH(4), .SAMPLE_W(16), .REC_LEN_W(16), .DECIM_W(8)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop), .mode(mode),
        .ch_mask(ch_mask), .rec_len(rec_len), .decim(decim), .aligned(aligned),
        .adc_data(adc_data), .fifo_rst(fifo_rst), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .wr_en(wr_en), .wr_data(wr_data), .wr_ch(wr_ch),
        .busy(busy), .done(done), .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int          log_cyc[$];
    logic [1:0]  log_ch[$];
    logic [15:0] log_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_cyc.push_back(cyc);
            log_ch.push_back(wr_ch);
            log_data.push_back(wr_data);
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_capture(output int e1);
        start = 1'b1;
        tick();
        start = 1'b0;
        e1 = cyc;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int k;
        k = 0;
        while ((state !== 3'd0 || busy !== 1'b0) && k < max_cyc) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= max_cyc) $display("FAIL %s_idle_timeout: state=%0d busy=%0b, required idle within %0d cycles", name, state, busy, max_cyc);
        else n_pass++;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 0; stop = 0; mode = 0; aligned = 1; fifo_rst = 0;
        fifo_full = 0; fifo_empty = 1; ch_mask = 4'b0001; rec_len = 16'd1;
        decim = 8'd0; adc_data = '0;
        repeat (3) tick();
        n_checks++; if (state !== 3'd0)    $display("FAIL reset_state: got %0d required 0", state);    else n_pass++;
        n_checks++; if (wr_en !== 1'b0)    $display("FAIL reset_wr_en: got %0b required 0", wr_en);    else n_pass++;
        n_checks++; if (wr_data !== 16'h0) $display("FAIL reset_wr_data: got %0h required 0", wr_data); else n_pass++;
        n_checks++; if (wr_ch !== 2'd0)    $display("FAIL reset_wr_ch: got %0d required 0", wr_ch);    else n_pass++;
        n_checks++; if (busy !== 1'b0)     $display("FAIL reset_busy: got %0b required 0", busy);      else n_pass++;
        n_checks++; if (done !== 1'b0)     $display("FAIL reset_done: got %0b required 0", done);      else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b required 0", overflow); else n_pass++;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_ignored_starts();
        int qb;
        qb = log_cyc.size();
        mode = 0; ch_mask = 4'b0011; rec_len = 16'd1; decim = 8'd0;
        // aligned low
        aligned = 0; start = 1; tick(); start = 0; tick();
        n_checks++; if (state !== 3'd0) $display("FAIL ign_aligned_state: got %0d required 0", state); else n_pass++;
        n_checks++; if (busy !== 1'b0)  $display("FAIL ign_aligned_busy: got %0b required 0", busy);   else n_pass++;
        // empty channel mask
        aligned = 1; ch_mask = 4'b0000; start = 1; tick(); start = 0; tick();
        n_checks++; if (state !== 3'd0) $display("FAIL ign_mask_state: got %0d required 0", state); else n_pass++;
        n_checks++; if (busy !== 1'b0)  $display("FAIL ign_mask_busy: got %0b required 0", busy);   else n_pass++;
        // zero record length
        ch_mask = 4'b0011; rec_len = 16'd0; start = 1; tick(); start = 0; tick();
        n_checks++; if (state !== 3'd0) $display("FAIL ign_reclen_state: got %0d required 0", state); else n_pass++;
        n_checks++; if (busy !== 1'b0)  $display("FAIL ign_reclen_busy: got %0b required 0", busy);   else n_pass++;
        repeat (3) tick();
        n_checks++; if (log_cyc.size() != qb) $display("FAIL ign_writes: got %0d writes required 0", log_cyc.size() - qb); else n_pass++;
    endtask

    task automatic test_one_shot();
        int e1, qb, db;
        int          ec[4];
        logic [1:0]  ech[4];
        logic [15:0] ed[4];
        qb = log_cyc.size(); db = done_cnt;
        mode = 0; ch_mask = 4'b0101; decim = 8'd3; rec_len = 16'd2;
        adc_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        start_capture(e1);
        n_checks++; if (state !== 3'd1) $display("FAIL os_wait_empty_state: got %0d required 1", state); else n_pass++;
        n_checks++; if (busy !== 1'b1)  $display("FAIL os_busy: got %0b required 1", busy);             else n_pass++;
        tick();
        n_checks++; if (state !== 3'd2) $display("FAIL os_capture_state: got %0d required 2", state); else n_pass++;
        wait_idle(40, "os");
        n_checks++; if (cyc != e1 + 9) $display("FAIL os_busy_fall: got cycle +%0d required +9", cyc - e1); else n_pass++;
        ec  = '{e1+2, e1+3, e1+6, e1+7};
        ech = '{2'd0, 2'd2, 2'd0, 2'd2};
        ed  = '{16'h1111, 16'h3333, 16'h1111, 16'h3333};
        n_checks++; if (log_cyc.size() - qb != 4) $display("FAIL os_write_count: got %0d required 4", log_cyc.size() - qb); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (qb + i >= log_cyc.size()) $display("FAIL os_write%0d: missing", i);
            else if (log_cyc[qb+i] != ec[i] || log_ch[qb+i] !== ech[i] || log_data[qb+i] !== ed[i])
                $display("FAIL os_write%0d: got cyc+%0d ch%0d %0h required cyc+%0d ch%0d %0h", i,
                         log_cyc[qb+i] - e1, log_ch[qb+i], log_data[qb+i], ec[i] - e1, ech[i], ed[i]);
            else n_pass++;
        end
        n_checks++; if (done_cnt - db != 1) $display("FAIL os_done_count: got %0d required 1", done_cnt - db); else n_pass++;
        n_checks++; if (done_cyc != e1 + 8) $display("FAIL os_done_cycle: got +%0d required +8", done_cyc - e1); else n_pass++;
        n_checks++; if (overflow !== 1'b0)  $display("FAIL os_overflow: got %0b required 0", overflow); else n_pass++;
    endtask

    task automatic test_overrun();
        int e1, qb, db;
        qb = log_cyc.size(); db = done_cnt;
        mode = 0; ch_mask = 4'b1111; decim = 8'd1; rec_len = 16'd3;
        adc_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        start_capture(e1);
        wait_idle(60, "ovr");
        // Every other tick is an overrun, so frames land 4 cycles apart.
        n_checks++; if (log_cyc.size() - qb != 12) $display("FAIL ovr_write_count: got %0d required 12", log_cyc.size() - qb); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (qb + i >= log_cyc.size()) $display("FAIL ovr_write%0d: missing", i);
            else if (log_cyc[qb+i] != e1 + 2 + 4*(i/4) + (i%4) || log_ch[qb+i] !== 2'(i%4)
                     || log_data[qb+i] !== 16'(16'h1111 * (i%4 + 1)))
                $display("FAIL ovr_write%0d: got cyc+%0d ch%0d %0h required cyc+%0d ch%0d %0h", i,
                         log_cyc[qb+i] - e1, log_ch[qb+i], log_data[qb+i], 2 + 4*(i/4) + (i%4), i%4, 16'h1111 * (i%4 + 1));
            else n_pass++;
        end
        n_checks++; if (overflow !== 1'b1)   $display("FAIL ovr_overflow: got %0b required 1", overflow); else n_pass++;
        n_checks++; if (done_cnt - db != 1)  $display("FAIL ovr_done_count: got %0d required 1", done_cnt - db); else n_pass++;
        n_checks++; if (done_cyc != e1 + 14) $display("FAIL ovr_done_cycle: got +%0d required +14", done_cyc - e1); else n_pass++;
    endtask

    task automatic test_fifo_full();
        int e1, qb, db;
        int          ec[6];
        logic [1:0]  ech[6];
        logic [15:0] ed[6];
        qb = log_cyc.size(); db = done_cnt;
        mode = 0; ch_mask = 4'b1111; decim = 8'd3; rec_len = 16'd2;
        adc_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        start_capture(e1);
        tick();
        tick();
        // Full while ch1 and ch2 of the first frame are being committed.
        fifo_full = 1;
        tick();
        tick();
        fifo_full = 0;
        n_checks++; if (overflow !== 1'b1) $display("FAIL full_overflow: got %0b required 1", overflow); else n_pass++;
        wait_idle(40, "full");
        ec  = '{e1+2, e1+5, e1+6, e1+7, e1+8, e1+9};
        ech = '{2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        ed  = '{16'hAAAA, 16'hDDDD, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        n_checks++; if (log_cyc.size() - qb != 6) $display("FAIL full_write_count: got %0d required 6", log_cyc.size() - qb); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (qb + i >= log_cyc.size()) $display("FAIL full_write%0d: missing", i);
            else if (log_cyc[qb+i] != ec[i] || log_ch[qb+i] !== ech[i] || log_data[qb+i] !== ed[i])
                $display("FAIL full_write%0d: got cyc+%0d ch%0d %0h required cyc+%0d ch%0d %0h", i,
                         log_cyc[qb+i] - e1, log_ch[qb+i], log_data[qb+i], ec[i] - e1, ech[i], ed[i]);
            else n_pass++;
        end
        n_checks++; if (done_cnt - db != 1)  $display("FAIL full_done_count: got %0d required 1", done_cnt - db); else n_pass++;
        n_checks++; if (done_cyc != e1 + 10) $display("FAIL full_done_cycle: got +%0d required +10", done_cyc - e1); else n_pass++;
    endtask

    task automatic test_continuous_stop();
        int e1, qb, db;
        qb = log_cyc.size(); db = done_cnt;
        mode = 1; ch_mask = 4'b0011; decim = 8'd3; rec_len = 16'd3;
        adc_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        start_capture(e1);
        // Run past rec_len frames, then request stop while frame 4 has ch1 pending.
        repeat (18) tick();
        stop = 1;
        wait_idle(30, "cont");
        stop = 0;
        mode = 0;
        n_checks++; if (log_cyc.size() - qb != 10) $display("FAIL cont_write_count: got %0d required 10", log_cyc.size() - qb); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (qb + i >= log_cyc.size()) $display("FAIL cont_write%0d: missing", i);
            else if (log_cyc[qb+i] != e1 + 2 + 4*(i/2) + (i%2) || log_ch[qb+i] !== 2'(i%2)
                     || log_data[qb+i] !== 16'(16'h1111 * (i%2 + 1)))
                $display("FAIL cont_write%0d: got cyc+%0d ch%0d %0h required cyc+%0d ch%0d %0h", i,
                         log_cyc[qb+i] - e1, log_ch[qb+i], log_data[qb+i], 2 + 4*(i/2) + (i%2), i%2, 16'h1111 * (i%2 + 1));
            else n_pass++;
        end
        n_checks++; if (done_cnt - db != 1)  $display("FAIL cont_done_count: got %0d required 1", done_cnt - db); else n_pass++;
        n_checks++; if (done_cyc != e1 + 20) $display("FAIL cont_done_cycle: got +%0d required +20", done_cyc - e1); else n_pass++;
        n_checks++; if (overflow !== 1'b0)   $display("FAIL cont_overflow: got %0b required 0", overflow); else n_pass++;
    endtask

    task automatic test_abort_and_reset();
        int e1, qb, db;
        qb = log_cyc.size(); db = done_cnt;
        mode = 0; ch_mask = 4'b1111; decim = 8'd3; rec_len = 16'd5;
        adc_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        start_capture(e1);
        tick();
        fifo_full = 1;              // drop ch0 so overflow is set before the abort
        tick();
        fifo_full = 0;
        fifo_rst = 1;
        tick();
        fifo_rst = 0;
        n_checks++; if (state !== 3'd0)    $display("FAIL abort_state: got %0d required 0", state);    else n_pass++;
        n_checks++; if (wr_en !== 1'b0)    $display("FAIL abort_wr_en: got %0b required 0", wr_en);    else n_pass++;
        n_checks++; if (busy !== 1'b0)     $display("FAIL abort_busy: got %0b required 0", busy);      else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL abort_overflow_kept: got %0b required 1", overflow); else n_pass++;
        repeat (5) tick();
        n_checks++; if (done_cnt != db)           $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt - db); else n_pass++;
        n_checks++; if (log_cyc.size() != qb)     $display("FAIL abort_writes: got %0d required 0", log_cyc.size() - qb); else n_pass++;
        n_checks++; if (state !== 3'd0)           $display("FAIL abort_stays_idle: got %0d required 0", state); else n_pass++;

        // Asynchronous reset in the middle of a capture.
        start_capture(e1);
        repeat (3) tick();
        n_checks++; if (wr_en !== 1'b1) $display("FAIL rst_pre_wr_en: got %0b required 1", wr_en); else n_pass++;
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (state !== 3'd0)    $display("FAIL rst_state: got %0d required 0", state);    else n_pass++;
        n_checks++; if (wr_en !== 1'b0)    $display("FAIL rst_wr_en: got %0b required 0", wr_en);    else n_pass++;
        n_checks++; if (wr_data !== 16'h0) $display("FAIL rst_wr_data: got %0h required 0", wr_data); else n_pass++;
        n_checks++; if (wr_ch !== 2'd0)    $display("FAIL rst_wr_ch: got %0d required 0", wr_ch);    else n_pass++;
        n_checks++; if (busy !== 1'b0)     $display("FAIL rst_busy: got %0b required 0", busy);      else n_pass++;
        n_checks++; if (done !== 1'b0)     $display("FAIL rst_done: got %0b required 0", done);      else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %0b required 0", overflow); else n_pass++;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_ignored_starts();
        test_one_shot();
        test_overrun();
        test_fifo_full();
        test_continuous_stop();
        test_abort_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_adc_capture_seq
`default_nettype wire

// File: doc/adc_capture_seq.md
# adc_capture_seq

Parametrised multi-channel capture sequencer; successor to the single-channel ADC write controller. Runs in the ADC divided-clock domain and takes a parallel snapshot of NUM_CH ADC channels at a programmable decimated rate. Serialises the enabled channels, lowest index first, into one channel-tagged FIFO write stream ahead of the width converter. Supports one-shot and continuous records, a frame-boundary stop, and sticky overflow reporting.

## Interface
Parameters:
- NUM_CH, 4, number of ADC channels (≥1)
- SAMPLE_W, 16, bits per sample
- REC_LEN_W, 16, width of record-length counter
- DECIM_W, 8, width of decimation divisor

Ports:
- clk  in  1  ADC divided clock; single clock domain
- rstn  in  1  asynchronous, active-low reset
- start  in  1  capture request; acted on at its rising edge
- stop  in  1  level; ends a continuous capture at the next frame boundary
- mode  in  1  0 = one-shot, 1 = continuous
- ch_mask  in  NUM_CH  channel enables; bit i enables channel i
- rec_len  in  REC_LEN_W  frames per record; 0 is rejected
- decim  in  DECIM_W  one frame every decim+1 cycles
- aligned  in  1  ADC deserialiser aligned
- adc_data  in  NUM_CH*SAMPLE_W  channel i occupies bits [i*SAMPLE_W +: SAMPLE_W]
- fifo_rst  in  1  FIFO reset busy (wr_rst_busy | rd_rst_busy)
- fifo_full  in  1  FIFO full (write domain)
- fifo_empty  in  1  FIFO empty (write domain)
- wr_en  out  1  FIFO write strobe
- wr_data  out  SAMPLE_W  sample
- wr_ch  out  max(1,$clog2(NUM_CH))  channel index of wr_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a record or a stop
- overflow  out  1  sticky; cleared only by an accepted start
- state  out  3  encoded FSM state, for ILA

## Operation
- FSM states: IDLE(0), WAIT_EMPTY(1), CAPTURE(2), FINISH(3).
- IDLE → WAIT_EMPTY on a start rising edge when aligned=1, fifo_rst=0, ch_mask≠0 and rec_len≠0. Otherwise the start is ignored.
- On an accepted start: latch mode, ch_mask, rec_len and decim; clear overflow, the frame counter and the decimation counter.
- WAIT_EMPTY → CAPTURE when fifo_empty=1 and fifo_rst=0.
- CAPTURE, decimation:
  - The decimation counter loads decim and counts down; a tick occurs when it is 0.
  - The first tick is on the first CAPTURE cycle.
  - On each tick, snapshot all of adc_data into a holding register and load the pending mask with the latched ch_mask.
- CAPTURE, serialisation:
  - Each cycle, the lowest set bit of the pending mask is written (wr_en=1, wr_data, wr_ch) and then cleared.
  - If fifo_full=1 at that write: suppress wr_en, drop the sample, set overflow, and still clear the bit.
- Overrun: a tick while the pending mask is nonzero sets overflow and discards that tick. The in-flight frame completes and the frame counter does not advance.
- Frame counting: a frame is counted when its last pending bit clears.
  - When the count reaches rec_len in one-shot mode: go to FINISH.
  - In continuous mode: reset the count and continue.
- stop=1 in continuous mode: go to FINISH at the next frame boundary, i.e. with the pending mask zero and no tick that cycle.
- FINISH: done=1 for one cycle, then IDLE.
- fifo_rst=1 in WAIT_EMPTY or CAPTURE aborts to IDLE immediately: pending mask cleared, no done pulse, overflow kept.
- aligned falling during CAPTURE: ignored.

## Timing
- All outputs are registered. Reset values: wr_en=0, wr_data=0, wr_ch=0, busy=0, done=0, overflow=0, state=IDLE(0).
- Start acceptance: start edge sampled at cycle t gives state=WAIT_EMPTY at t+1. With the FIFO already empty, CAPTURE at t+2.
- Tick at cycle t: the k-th enabled channel (k=0..) has wr_en high at t+1+k with the snapshot taken at t.
- No-overrun condition: popcount(ch_mask) ≤ decim+1.
- Write stream: no bubbles within a frame; consecutive frames are back-to-back when popcount = decim+1.
- done asserts the cycle after the last write of the record; busy falls the cycle after that.

## Structure
- Package adc_capture_pkg holds:
  - capture_state_t enum (IDLE, WAIT_EMPTY, CAPTURE, FINISH), 3 bits
  - capture_mode_t enum (ONE_SHOT, CONTINUOUS)
- Sub-module channel_serializer (NUM_CH, SAMPLE_W) owns:
  - snapshot register, pending mask, lowest-set-bit priority encoder
  - outputs: valid, data, ch, last, and a busy flag
- The top level owns the FSM, the decimation and frame counters, and overflow.

## Test plan
- NUM_CH=4, ch_mask=4'b0101, decim=3, rec_len=2, one-shot, adc_data ch0=0x1111, ch2=0x3333 → writes (ch0,0x1111),(ch2,0x3333) twice, 4 cycles apart; one done pulse; overflow=0.
- ch_mask=4'b1111, decim=1 → overrun; overflow=1; every frame written still contains all 4 channels in order 0..3.
- fifo_full held high for 2 cycles mid-frame → the 2 writes due in that window are suppressed, overflow=1, later channels and frames are written normally.
- Continuous mode, rec_len=3, stop asserted mid-frame → the current frame completes, done pulses, state returns to IDLE, no partial frame.
- start edge with aligned=0, then with ch_mask=0, then with rec_len=0 → each ignored; state stays IDLE, busy=0.
- fifo_rst pulse during CAPTURE → state returns to IDLE the next cycle, wr_en=0, no done; rstn low mid-capture → all outputs at their reset values.
